cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Exception/interrupt sequencing controller for CP0. It arbitrates synchronous exception requests against masked hardware interrupts and drains the pipeline. It then commits EPC/Cause and sets Status.EXL through the status unit's write strobes, and redirects fetch to the exception vector. It also sequences ERET: clears EXL/ERL through the status unit's `eret` strobe and redirects fetch to EPC.

## Interface
Parameters:
- `VEC_BASE`, 32'hBFC0_0200: exception vector base; general vector = `VEC_BASE + 32'h180`.
- `DRAIN_MAX`, 15: maximum DRAIN cycles before forced commit (4-bit counter).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `exc_req`  in  6  {bp, sys, ov, ri, ades, adel}; level requests from the WB-stage instruction.
- `int_pend`  in  8  Cause.IP.
- `status_im`  in  8  Status.IM.
- `status_ie`, `status_exl`, `status_erl`  in  1 each  current Status bits.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_bd`  in  1  faulting instruction is in a delay slot.
- `eret_req`  in  1  ERET at WB.
- `epc_in`  in  32  current EPC.
- `pipe_empty`  in  1  pipeline drained acknowledge.
- `flush`  out  1  pipeline flush, held through DRAIN.
- `epc_we`  out  1  EPC write strobe.
- `epc_data`  out  32  EPC value.
- `cause_we`  out  1  Cause.ExcCode/BD write strobe.
- `exc_code`  out  5  ExcCode.
- `cause_bd`  out  1  BD bit.
- `set_exl`  out  1  Status EXL write: status unit loads EXL=1.
- `eret`  out  1  ERET strobe to the status unit.
- `pc_redirect`  out  1  fetch redirect pulse.
- `pc_target`  out  32  redirect address.
- `busy`  out  1  FSM not in IDLE.
- `drain_err`  out  1  sticky: DRAIN timed out.

## Operation
- Priority, highest first, with ExcCode: adel 4, ades 5, ri 10, ov 12, sys 8, bp 9, interrupt 0.
- Interrupt is valid only when `status_ie & ~status_exl & ~status_erl & |(int_pend & status_im)`.
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT, RET.
- **IDLE, exception or valid interrupt:**
  - Latch code, `exc_bd`, and EPC = `exc_bd ? exc_pc - 4 : exc_pc` (32-bit wrap).
  - Go to DRAIN.
- **IDLE, `eret_req` with no exception:** go to RET. A simultaneous exception wins and ERET is dropped.
- **DRAIN:**
  - `flush`=1 and the counter increments each cycle.
  - Exit to COMMIT on `pipe_empty`, or when counter = `DRAIN_MAX`; the timeout case also sets `drain_err`.
- **COMMIT:** one-cycle pulse of `epc_we`, `cause_we`, `set_exl`; `epc_data`/`exc_code`/`cause_bd` carry the latched values. Go to REDIRECT.
- **REDIRECT:** one-cycle `pc_redirect`, `pc_target` = `VEC_BASE + 32'h180`. Go to IDLE.
- **RET:** one-cycle `eret` and `pc_redirect` with `pc_target` = `epc_in`. Go to IDLE.
- All requests are ignored while `busy`; no queueing.
- `drain_err` clears only on reset.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and the counter to 0. Reset asserted mid-sequence aborts immediately and no strobe completes.
- Exception accepted at edge N: `flush` is high from cycle N+1.
- With `pipe_empty` high in the first DRAIN cycle: COMMIT at N+2, REDIRECT at N+3, IDLE at N+4.
- ERET accepted at edge N: `eret` and `pc_redirect` are high in cycle N+1.
- `set_exl` at COMMIT makes `status_exl`=1 by the following cycle, so a pending interrupt cannot re-trigger on return to IDLE.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path except `pc_target` = `epc_in` in RET.

## Structure
- Shared `cp0_pkg`:
  - ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - FSM state encoding.
  - General vector offset 32'h180.
- Sub-module `cp0_exc_prio`: combinational priority encoder with inputs {exc_req, int_pend, status_im, status_ie, status_exl, status_erl} and outputs {take, code}.

## Test plan
- `exc_req`=6'b000100 (ri), `exc_pc`=32'h0040_0010, `exc_bd`=0, `pipe_empty`=1 → COMMIT with `epc_data`=32'h0040_0010, `exc_code`=10; then REDIRECT with `pc_target`=32'hBFC0_0380.
- `exc_req`=6'b100001 (bp+adel), `exc_bd`=1, `exc_pc`=32'h0000_0004 → `exc_code`=4, `cause_bd`=1, `epc_data`=32'h0000_0000.
- `int_pend`=8'h04, `status_im`=8'h04, `status_ie`=1, `status_exl`=0 → `exc_code`=0.
  - Same with `status_exl`=1 → no `busy`.
- `eret_req`=1, `epc_in`=32'h0040_0100, no exception → next cycle `eret`=1, `pc_redirect`=1, `pc_target`=32'h0040_0100.
  - `eret_req` together with ov → ov sequence, no `eret`.
- `pipe_empty` held 0 → `flush` high 16 cycles, `drain_err`=1, COMMIT follows.
  - Assert `rst`=0 during DRAIN → all outputs 0 at once; `busy`=0 after release.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, the exception FSM encoding and
// the general exception vector offset.
package cp0_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_GEN_OFFSET = 32'h0000_0180;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_RET      = 3'd4
    } exc_state_e;

    // A delay-slot fault restarts at the branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational exception/interrupt priority encoder: picks the highest
// priority synchronous exception, falling back to a masked, enabled interrupt.
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic [5:0] exc_req,
    input  logic [7:0] int_pend,
    input  logic [7:0] status_im,
    input  logic       status_ie,
    input  logic       status_exl,
    input  logic       status_erl,
    output logic       take,
    output logic [4:0] code
);

    logic [7:0] int_hit;
    logic       int_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_int_hit
            assign int_hit[gi] = int_pend[gi] & status_im[gi];
        end
    endgenerate

    assign int_valid = status_ie & ~status_exl & ~status_erl & (|int_hit);

    // exc_req bit order is {bp, sys, ov, ri, ades, adel}.
    always_comb begin
        take = 1'b1;
        code = EXC_INT;
        if (exc_req[0]) begin
            code = EXC_ADEL;
        end else if (exc_req[1]) begin
            code = EXC_ADES;
        end else if (exc_req[2]) begin
            code = EXC_RI;
        end else if (exc_req[3]) begin
            code = EXC_OV;
        end else if (exc_req[4]) begin
            code = EXC_SYS;
        end else if (exc_req[5]) begin
            code = EXC_BP;
        end else begin
            code = EXC_INT;
            take = int_valid;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer: drains the pipeline, commits EPC/Cause/EXL
// through write strobes and redirects fetch to the vector or back to EPC.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'hBFC0_0200,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  exc_req,
    input  logic [7:0]  int_pend,
    input  logic [7:0]  status_im,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic        status_erl,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    input  logic        pipe_empty,
    output logic        flush,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        cause_we,
    output logic [4:0]  exc_code,
    output logic        cause_bd,
    output logic        set_exl,
    output logic        eret,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        busy,
    output logic        drain_err
);

    localparam logic [3:0]  DRAIN_LIMIT = 4'(DRAIN_MAX);
    localparam logic [31:0] VEC_GEN     = VEC_BASE + VEC_GEN_OFFSET;

    exc_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;
    logic        drain_err_q, drain_err_d;

    logic        prio_take;
    logic [4:0]  prio_code;

    cp0_exc_prio u_prio (
        .exc_req    (exc_req),
        .int_pend   (int_pend),
        .status_im  (status_im),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .status_erl (status_erl),
        .take       (prio_take),
        .code       (prio_code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            bd_q        <= 1'b0;
            epc_q       <= '0;
            drain_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            bd_q        <= bd_d;
            epc_q       <= epc_d;
            drain_err_q <= drain_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        bd_d        = bd_q;
        epc_d       = epc_q;
        drain_err_d = drain_err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // An exception in the same cycle as ERET wins; the ERET is dropped.
                if (prio_take) begin
                    code_d  = prio_code;
                    bd_d    = exc_bd;
                    epc_d   = epc_of(exc_pc, exc_bd);
                    state_d = ST_DRAIN;
                end else if (eret_req) begin
                    state_d = ST_RET;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_COMMIT;
                end else if (cnt_q == DRAIN_LIMIT) begin
                    state_d     = ST_COMMIT;
                    drain_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            ST_RET:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    logic in_commit;
    assign in_commit = (state_q == ST_COMMIT);

    assign flush       = (state_q == ST_DRAIN);
    assign epc_we      = in_commit;
    assign cause_we    = in_commit;
    assign set_exl     = in_commit;
    assign epc_data    = in_commit ? epc_q  : 32'd0;
    assign exc_code    = in_commit ? code_q : 5'd0;
    assign cause_bd    = in_commit & bd_q;
    assign eret        = (state_q == ST_RET);
    assign pc_redirect = (state_q == ST_REDIRECT) || (state_q == ST_RET);
    assign busy        = (state_q != ST_IDLE);
    assign drain_err   = drain_err_q;

    // epc_in is the one input allowed to reach an output combinationally.
    always_comb begin
        pc_target = 32'd0;
        if (state_q == ST_REDIRECT) begin
            pc_target = VEC_GEN;
        end else if (state_q == ST_RET) begin
            pc_target = epc_in;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: expected strobe events are queued as
// stimulus is applied and popped by a monitor whenever the DUT emits one.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  exc_req;
    logic [7:0]  int_pend;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic        status_erl;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret_req;
    logic [31:0] epc_in;
    logic        pipe_empty;
    logic        flush;
    logic        epc_we;
    logic [31:0] epc_data;
    logic        cause_we;
    logic [4:0]  exc_code;
    logic        cause_bd;
    logic        set_exl;
    logic        eret;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        busy;
    logic        drain_err;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct packed {
        logic [4:0]  strb;   // {epc_we, cause_we, set_exl, pc_redirect, eret}
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] tgt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;

    cp0_exc_ctrl #(.VEC_BASE(32'hBFC0_0200), .DRAIN_MAX(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_req     (exc_req),
        .int_pend    (int_pend),
        .status_im   (status_im),
        .status_ie   (status_ie),
        .status_exl  (status_exl),
        .status_erl  (status_erl),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .eret_req    (eret_req),
        .epc_in      (epc_in),
        .pipe_empty  (pipe_empty),
        .flush       (flush),
        .epc_we      (epc_we),
        .epc_data    (epc_data),
        .cause_we    (cause_we),
        .exc_code    (exc_code),
        .cause_bd    (cause_bd),
        .set_exl     (set_exl),
        .eret        (eret),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .busy        (busy),
        .drain_err   (drain_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, obs);
        end
    endtask

    task automatic push_ev(input logic [4:0] strb, input logic [31:0] epc,
                           input logic [4:0] code, input logic bd, input logic [31:0] tgt);
        ev_t e;
        e.strb = strb; e.epc = epc; e.code = code; e.bd = bd; e.tgt = tgt;
        exp_q.push_back(e);
    endtask

    // Exception sequence: a COMMIT event followed by a vector REDIRECT.
    task automatic push_exc(input logic [31:0] epc, input logic [4:0] code, input logic bd);
        push_ev(5'b11100, epc, code, bd, 32'd0);
        push_ev(5'b00010, 32'd0, 5'd0, 1'b0, VEC);
    endtask

    always @(negedge clk) begin
        if (rst && (epc_we || cause_we || set_exl || pc_redirect || eret)) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_event", {27'd0, epc_we, cause_we, set_exl, pc_redirect, eret}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("ev_strobes", {27'd0, epc_we, cause_we, set_exl, pc_redirect, eret}, {27'd0, mon_e.strb});
                check_val("ev_epc_data", epc_data, mon_e.epc);
                check_val("ev_exc_code", {27'd0, exc_code}, {27'd0, mon_e.code});
                check_val("ev_cause_bd", {31'd0, cause_bd}, {31'd0, mon_e.bd});
                check_val("ev_pc_target", pc_target, mon_e.tgt);
            end
        end
    end

    // Drives one request into IDLE, clears it after the accepting edge and
    // checks that flush rises in the very next cycle.
    task automatic run_exc(input logic [5:0] req, input logic [31:0] pc, input logic bd,
                           input logic pe, input logic [7:0] ip, input logic [7:0] im,
                           input logic ie, input logic exl);
        exc_req = req; exc_pc = pc; exc_bd = bd; pipe_empty = pe;
        int_pend = ip; status_im = im; status_ie = ie; status_exl = exl;
        @(posedge clk); #1;
        exc_req = '0; int_pend = '0; eret_req = 1'b0;
        @(negedge clk);
        check_val("flush_after_accept", {31'd0, flush}, 32'd1);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (busy) check_val("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int cyc;
        int nflush;
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nflush;
        rst = 1'b0; exc_req = '0; int_pend = '0; status_im = '0; status_ie = 1'b0;
        status_exl = 1'b0; status_erl = 1'b0; exc_pc = '0; exc_bd = 1'b0;
        eret_req = 1'b0; epc_in = '0; pipe_empty = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_outputs", {31'd0, |{flush, epc_we, epc_data, cause_we, exc_code, cause_bd,
                  set_exl, eret, pc_redirect, pc_target, busy, drain_err}}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_after_reset", {31'd0, busy}, 32'd0);

        // ri, no delay slot; expect 3 cycles from first DRAIN cycle to IDLE
        push_exc(32'h0040_0010, 5'd10, 1'b0);
        run_exc(6'b000100, 32'h0040_0010, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);
        check_val("ri_latency", cyc, 32'd3);

        // bp+adel in delay slot: adel wins, EPC backs up one word
        push_exc(32'h0000_0000, 5'd4, 1'b1);
        run_exc(6'b100001, 32'h0000_0004, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);

        // sys in delay slot at PC 0: EPC wraps
        push_exc(32'hFFFF_FFFC, 5'd8, 1'b1);
        run_exc(6'b010000, 32'h0000_0000, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);

        // ades over ov, plain bp alone
        push_exc(32'h1234_5678, 5'd5, 1'b0);
        run_exc(6'b001010, 32'h1234_5678, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);
        push_exc(32'h0000_0100, 5'd9, 1'b0);
        run_exc(6'b100000, 32'h0000_0100, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);

        // enabled, masked-in interrupt
        push_exc(32'h0040_0200, 5'd0, 1'b0);
        run_exc(6'b000000, 32'h0040_0200, 1'b0, 1'b1, 8'h04, 8'h04, 1'b1, 1'b0);
        wait_idle(cyc);

        // same interrupt with EXL set, then with IM not covering it: ignored
        int_pend = 8'h04; status_im = 8'h04; status_ie = 1'b1; status_exl = 1'b1;
        repeat (3) @(negedge clk);
        check_val("int_exl_masked", {31'd0, busy}, 32'd0);
        status_exl = 1'b0; status_im = 8'h08;
        repeat (3) @(negedge clk);
        check_val("int_im_masked", {31'd0, busy}, 32'd0);
        int_pend = '0; status_im = '0; status_ie = 1'b0;

        // ERET alone
        push_ev(5'b00011, 32'd0, 5'd0, 1'b0, 32'h0040_0100);
        epc_in = 32'h0040_0100; eret_req = 1'b1;
        @(posedge clk); #1;
        eret_req = 1'b0;
        @(negedge clk);
        check_val("eret_pulse", {30'd0, eret, pc_redirect}, 32'd3);
        @(negedge clk);
        check_val("eret_done", {31'd0, busy}, 32'd0);

        // ERET with ov in the same cycle: exception wins, no eret strobe
        push_exc(32'h0040_0300, 5'd12, 1'b0);
        eret_req = 1'b1;
        run_exc(6'b001000, 32'h0040_0300, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);
        check_val("no_drain_err_yet", {31'd0, drain_err}, 32'd0);

        // DRAIN timeout
        push_exc(32'h0040_0400, 5'd10, 1'b0);
        run_exc(6'b000100, 32'h0040_0400, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        nflush = 1;
        while (flush && nflush < 40) begin
            @(negedge clk);
            if (flush) nflush++;
        end
        check_val("drain_flush_cycles", nflush, 32'd16);
        check_val("drain_err_set", {31'd0, drain_err}, 32'd1);
        pipe_empty = 1'b1;
        wait_idle(cyc);
        check_val("drain_err_sticky", {31'd0, drain_err}, 32'd1);

        // Reset in the middle of DRAIN
        pipe_empty = 1'b0;
        exc_req = 6'b000100; exc_pc = 32'h0040_0500;
        @(posedge clk); #1;
        exc_req = '0;
        @(negedge clk);
        check_val("flush_before_reset", {31'd0, flush}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_val("reset_mid_drain", {31'd0, |{flush, epc_we, epc_data, cause_we, exc_code, cause_bd,
                  set_exl, eret, pc_redirect, pc_target, busy, drain_err}}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pipe_empty = 1'b1;
        @(negedge clk);
        check_val("idle_after_abort", {31'd0, busy}, 32'd0);

        // Normal operation resumes after the abort
        push_exc(32'h0040_0600, 5'd12, 1'b0);
        run_exc(6'b001000, 32'h0040_0600, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle(cyc);

        repeat (2) @(negedge clk);
        check_val("events_pending", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
